vga_text_sched: RTL and testbench

// - Text-overlay scheduler for the glyph lookup (VGA_char). Holds a ROWS x COLS character buffer written by game logic.
// - Maps the live VGA pixel position to char code / dH / dV / dcnt for the glyph lookup, then registers its Point reply as pix_on.
// - Sits between the VGA sync counters and the colour mux; owns buffer clear sequencing and the blink phase.

---
 rtl/vga_text_sched.sv | 192 +++++++++++++++++++
 tb/tb_vga_text_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_sched.sv
// Text-overlay scheduler: character buffer, clear sweep and 3-stage pixel pipeline to the glyph lookup.
// Optional blink phase counter is built only when TEXT_BLINK_EN is defined.
module vga_text_sched #(
    parameter int          COLS         = 16,
    parameter int          ROWS         = 2,
    parameter int          AW           = 5,
    parameter logic [9:0]  X0           = 10'd256,
    parameter logic [9:0]  Y0           = 10'd200,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [9:0]    hcnt,
    input  logic [9:0]    vcnt,
    input  logic          de,
    input  logic          frame_tick,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [5:0]    wr_data,
    output logic          wr_ready,
    input  logic          clr_req,
    output logic          busy,
    output logic [5:0]    alph,
    output logic [2:0]    dH,
    output logic [3:0]    dV,
    output logic [9:0]    dcnt,
    input  logic          point_in,
    output logic          pix_on,
    output logic          pix_valid
);

    localparam int N  = COLS * ROWS;
    localparam int CB = $clog2(COLS);
    localparam int RB = AW - CB;
    localparam logic [10:0]   X_END     = {1'b0, X0} + 11'(8 * COLS);
    localparam logic [10:0]   Y_END     = {1'b0, Y0} + 11'(16 * ROWS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [AW-1:0]   clr_addr_r;
    logic            busy_r, wr_ready_r;
    logic [5:0]      mem_r [0:N-1];
    logic            mem_we_s;
    logic [AW-1:0]   mem_waddr_s;
    logic [5:0]      mem_wdata_s;
    logic [9:0]      rx_s, ry_s;
    logic            in_box_s;
    logic [AW-1:0]   addr_s;
    logic            in_box_r, in_box_dd_r;
    logic [AW-1:0]   addr_r;
    logic [2:0]      gh_r, dh_r;
    logic [3:0]      gv_r, dv_r;
    logic [2:0]      de_d_r;
    logic [5:0]      alph_r;
    logic            pix_on_r;
    logic [9:0]      dcnt_r;
    logic            unused_s;

    // Next-state decode for the clear sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clr_req) state_nxt_s = ST_CLEAR;
                else         state_nxt_s = ST_IDLE;
            end
            ST_CLEAR: begin
                if (clr_addr_r == LAST_ADDR) state_nxt_s = ST_DONE;
                else                         state_nxt_s = ST_CLEAR;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_CLEAR;
        endcase
    end

    // State register, sweep address and registered handshake flags; reset starts a fresh sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_CLEAR;
            clr_addr_r <= {AW{1'b0}};
            busy_r     <= 1'b1;
            wr_ready_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            busy_r     <= (state_nxt_s == ST_CLEAR);
            wr_ready_r <= (state_nxt_s == ST_IDLE);
            if ((state_r == ST_CLEAR) && (state_nxt_s == ST_CLEAR)) clr_addr_r <= clr_addr_r + {{(AW-1){1'b0}}, 1'b1};
            else                                                    clr_addr_r <= {AW{1'b0}};
        end
    end

    // Single write port shared by the sweep and game logic; out-of-range codes become space.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = {AW{1'b0}};
        mem_wdata_s = 6'd0;
        if (state_r == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_addr_r;
            mem_wdata_s = 6'd0;
        end else if (wr_en && wr_ready_r) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = wr_addr;
            mem_wdata_s = (wr_data > 6'd53) ? 6'd0 : wr_data;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Character buffer storage; contents are defined by the sweep, not by reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) mem_r[mem_waddr_s] <= mem_wdata_s;
    end

    assign rx_s     = hcnt - X0;
    assign ry_s     = vcnt - Y0;
    assign in_box_s = de && ({1'b0, hcnt} >= {1'b0, X0}) && ({1'b0, hcnt} < X_END)
                         && ({1'b0, vcnt} >= {1'b0, Y0}) && ({1'b0, vcnt} < Y_END);
    assign addr_s   = {ry_s[4 +: RB], rx_s[3 +: CB]};

    // Three-stage pixel pipeline: position decode, buffer read (read-first), lit pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_box_r    <= 1'b0;
            addr_r      <= {AW{1'b0}};
            gh_r        <= 3'd0;
            gv_r        <= 4'd0;
            in_box_dd_r <= 1'b0;
            alph_r      <= 6'd0;
            dh_r        <= 3'd0;
            dv_r        <= 4'd0;
            pix_on_r    <= 1'b0;
            de_d_r      <= 3'd0;
        end else begin
            in_box_r    <= in_box_s;
            addr_r      <= addr_s;
            gh_r        <= in_box_s ? rx_s[2:0] : 3'd0;
            gv_r        <= in_box_s ? ry_s[3:0] : 4'd0;
            in_box_dd_r <= in_box_r;
            alph_r      <= (in_box_r && !busy_r) ? mem_r[addr_r] : 6'd0;
            dh_r        <= gh_r;
            dv_r        <= gv_r;
            pix_on_r    <= in_box_dd_r && point_in && !busy_r;
            de_d_r      <= {de_d_r[1:0], de};
        end
    end

`ifdef TEXT_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    logic [FW-1:0] frame_cnt_r;

    // Blink phase: dcnt advances once every BLINK_FRAMES frames.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_r <= {FW{1'b0}};
            dcnt_r      <= 10'd0;
        end else if (frame_tick) begin
            if (frame_cnt_r == FRAME_LAST) begin
                frame_cnt_r <= {FW{1'b0}};
                dcnt_r      <= dcnt_r + 10'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r + {{(FW-1){1'b0}}, 1'b1};
            end
        end
    end
`else
    // Steady text: blink phase pinned at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) dcnt_r <= 10'd0;
        else        dcnt_r <= 10'd0;
    end
`endif

    assign unused_s  = ^{frame_tick, rx_s, ry_s};

    assign wr_ready  = wr_ready_r;
    assign busy      = busy_r;
    assign alph      = alph_r;
    assign dH        = dh_r;
    assign dV        = dv_r;
    assign dcnt      = dcnt_r;
    assign pix_on    = pix_on_r;
    assign pix_valid = de_d_r[2];

endmodule

// File: tb/tb_vga_text_sched.sv
// Directed self-checking bench for vga_text_sched; models the glyph lookup for 'A' row 4 (8'h36).
// Blink expectations follow TEXT_BLINK_EN when it is defined for the build.
module tb_vga_text_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] hcnt, vcnt;
    logic       de, frame_tick;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [5:0] wr_data;
    logic       wr_ready, clr_req, busy;
    logic [5:0] alph;
    logic [2:0] d_h;
    logic [3:0] d_v;
    logic [9:0] dcnt;
    logic       point_in, pix_on, pix_valid;
    logic [7:0] glyph_row = 8'h36;

    int total = 0;
    int bad   = 0;

    vga_text_sched #(.BLINK_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n), .hcnt(hcnt), .vcnt(vcnt), .de(de),
        .frame_tick(frame_tick), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .clr_req(clr_req), .busy(busy), .alph(alph),
        .dH(d_h), .dV(d_v), .dcnt(dcnt), .point_in(point_in), .pix_on(pix_on),
        .pix_valid(pix_valid)
    );

    always #5 clk = ~clk;

    // Glyph lookup model: only 'A' row 4 is lit; odd blink phase blanks it.
    assign point_in = (alph == 6'd1) && (d_v == 4'd4) && !dcnt[0] && glyph_row[3'd7 - d_h];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic do_write(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = 5'(a);
        wr_data = 6'(d);
        step();
        wr_en   = 1'b0;
    endtask

    task automatic rd(input int a, output logic [5:0] c);
        hcnt = 10'(256 + 8 * (a % 16));
        vcnt = 10'(200 + 16 * (a / 16));
        de   = 1'b1;
        step();
        step();
        c    = alph;
        de   = 1'b0;
    endtask

    task automatic pix(input int h, input int v, output logic p);
        hcnt = 10'(h);
        vcnt = 10'(v);
        de   = 1'b1;
        step();
        step();
        step();
        p    = pix_on;
        de   = 1'b0;
    endtask

    initial begin
        logic [5:0] c;
        logic       p;
        logic [7:0] lit_exp;
        int         n;
        int         dexp [4];
        logic       blink_pix;
`ifdef TEXT_BLINK_EN
        dexp      = '{0, 1, 1, 2};
        blink_pix = 1'b0;
`else
        dexp      = '{0, 0, 0, 0};
        blink_pix = 1'b1;
`endif
        lit_exp = 8'b0011_0110;
        rst_n = 1'b0; hcnt = 10'd0; vcnt = 10'd0; de = 1'b0; frame_tick = 1'b0;
        wr_en = 1'b0; wr_addr = 5'd0; wr_data = 6'd0; clr_req = 1'b0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_alph", 32'(alph), 32'd0);
        chk("rst_pix_on", 32'(pix_on), 32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_dcnt", 32'(dcnt), 32'd0);

        // Post-reset sweep: 32 busy cycles, one DONE cycle, then ready.
        rst_n = 1'b1;
        repeat (31) step();
        chk("sweep_busy_c31", 32'(busy), 32'd1);
        step();
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_wr_ready", 32'(wr_ready), 32'd0);
        step();
        chk("idle_wr_ready", 32'(wr_ready), 32'd1);
        for (int a = 0; a < 32; a++) begin
            rd(a, c);
            chk("blank_after_reset", 32'(c), 32'd0);
        end

        // 'A' at addr 0, scan glyph row 4 across the first cell.
        do_write(0, 1);
        vcnt = 10'd204;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) begin
                hcnt = 10'(256 + i);
                de   = 1'b1;
            end else begin
                de   = 1'b0;
            end
            step();
            if (i >= 1 && i < 9) begin
                chk("scan_alph", 32'(alph), 32'd1);
                chk("scan_dH", 32'(d_h), 32'(i - 1));
                chk("scan_dV", 32'(d_v), 32'd4);
            end
            if (i >= 2 && i < 10) begin
                chk("scan_pix_on", 32'(pix_on), 32'(lit_exp[7 - (i - 2)]));
                chk("scan_pix_valid", 32'(pix_valid), 32'd1);
            end
        end

        // Just outside the box on each side, de high.
        pix(255, 204, p);
        chk("left_alph", 32'(alph), 32'd0);
        chk("left_pix_on", 32'(p), 32'd0);
        chk("left_pix_valid", 32'(pix_valid), 32'd1);
        pix(384, 204, p);
        chk("right_alph", 32'(alph), 32'd0);
        chk("right_pix_on", 32'(p), 32'd0);
        pix(258, 232, p);
        chk("below_alph", 32'(alph), 32'd0);
        chk("below_pix_on", 32'(p), 32'd0);
        chk("below_pix_valid", 32'(pix_valid), 32'd1);
        pix(258, 204, p);
        chk("inside_lit", 32'(p), 32'd1);
        hcnt = 10'd258; vcnt = 10'd204; de = 1'b0;
        repeat (3) step();
        chk("de_low_alph", 32'(alph), 32'd0);
        chk("de_low_pix_valid", 32'(pix_valid), 32'd0);

        // Last cell, last pixel.
        do_write(31, 53);
        hcnt = 10'd383; vcnt = 10'd231; de = 1'b1;
        step(); step();
        chk("corner_alph", 32'(alph), 32'd53);
        chk("corner_dH", 32'(d_h), 32'd7);
        chk("corner_dV", 32'(d_v), 32'd15);
        de = 1'b0;

        do_write(17, 20);
        rd(17, c);
        chk("addr17_write", 32'(c), 32'd20);
        do_write(17, 54);
        rd(17, c);
        chk("addr17_out_of_range", 32'(c), 32'd0);

        // Read and write addr 5 on the same edge: old code first.
        hcnt = 10'd296; vcnt = 10'd200; de = 1'b1;
        step();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 6'd9;
        step();
        wr_en = 1'b0;
        chk("collide_old", 32'(alph), 32'd0);
        step();
        chk("collide_new", 32'(alph), 32'd9);
        de = 1'b0;

        // Clear request; a second request mid-sweep must not restart it.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        chk("clr_busy", 32'(busy), 32'd1);
        chk("clr_wr_ready", 32'(wr_ready), 32'd0);
        n = 0;
        while (busy && n < 40) begin
            clr_req = (n == 10);
            step();
            n++;
        end
        clr_req = 1'b0;
        chk("clr_sweep_len", 32'(n), 32'd32);
        chk("clr_done_wr_ready", 32'(wr_ready), 32'd0);
        do_write(17, 26);
        chk("clr_idle_wr_ready", 32'(wr_ready), 32'd1);
        rd(17, c);
        chk("dropped_write", 32'(c), 32'd0);
        rd(31, c);
        chk("cleared_addr31", 32'(c), 32'd0);
        rd(5, c);
        chk("cleared_addr5", 32'(c), 32'd0);

        // Blink phase.
        do_write(0, 1);
        for (int k = 0; k < 4; k++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            chk("dcnt_step", 32'(dcnt), 32'(dexp[k]));
            if (k == 1) begin
                pix(258, 204, p);
                chk("blink_odd_pix", 32'(p), 32'(blink_pix));
            end
        end
        pix(258, 204, p);
        chk("blink_even_pix", 32'(p), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
